rv32i_decode: RTL and testbench

- RV32I instruction decoder in the ID stage; registered outputs.
- Splits a 32-bit instruction into register indices and raw immediates, and builds 32-bit sign- and zero-extended immediates.
- Generates ALU, memory, write-back and branch control for the execute/memory/write-back stages.
- pc_sel flushes the stage, inserting a bubble.

---
 rtl/rv32i_decode.sv | 236 +++++++++++++++++++++++
 tb/tb_rv32i_decode.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_decode.sv
// rv32i_decode -- RV32I instruction decoder for the ID stage.
//
// Splits the instruction word into register indices and raw immediate
// fields. Builds the format-selected immediate in sign- and zero-extended
// form, and generates ALU, memory, write-back and branch control for the
// later stages. The decode is combinational and every output is registered,
// so the latency is one cycle.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset; all outputs 0 (NOP)
//   in[31:0]      instruction word
//   pc_sel        redirect/flush; the next edge captures an all-zero bubble
//   rs1/rs2/rd    register indices (rs1 forced 0 for LUI, AUIPC, JAL)
//   imm_i/imm_u/imm_s/imm_b/imm_j  raw immediate fields
//   sign_ext_imm  format immediate, sign-extended
//   zero_ext_imm  format immediate, zero-extended
//   alu_op        operation class (111 = illegal)
//   alu_src       [0] operand B = immediate, [1] operand A = PC
//   branch_sel    000 none, 001..110 BEQ..BGEU, 111 JAL/JALR
//   mr_sel        memory read
//   mtr_sel       write-back from memory
//   mw_sel        memory write
//   rw_sel        register write enable (never set for rd = x0)
//   illegal       only with DECODE_ILLEGAL_EN defined: illegal instruction
//
// Optional feature: define DECODE_ILLEGAL_EN to add the `illegal` output.
// With it defined, an R-type funct7 other than 0000000/0100000 is also
// decoded as illegal.

module rv32i_decode (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in,
    input  logic        pc_sel,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [11:0] imm_i,
    output logic [19:0] imm_u,
    output logic [11:0] imm_s,
    output logic [11:0] imm_b,
    output logic [11:0] imm_j,
    output logic [31:0] sign_ext_imm,
    output logic [31:0] zero_ext_imm,
    output logic [2:0]  alu_op,
    output logic [1:0]  alu_src,
    output logic [2:0]  branch_sel,
    output logic        mr_sel,
    output logic        mtr_sel,
    output logic        mw_sel,
    output logic        rw_sel
`ifdef DECODE_ILLEGAL_EN
    ,
    output logic        illegal
`endif
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [11:0] d_imm_s;
    logic [11:0] d_imm_b;
    logic [11:0] d_imm_j;

    assign opcode  = in[6:0];
    assign funct3  = in[14:12];
    assign d_imm_s = {in[31:25], in[11:7]};
    assign d_imm_b = {in[31], in[7], in[30:25], in[11:8]};
    assign d_imm_j = {in[20], in[30:21], 1'b0};

    logic [4:0]  d_rs1;
    logic [31:0] d_sx;
    logic [31:0] d_zx;
    logic [2:0]  d_alu_op;
    logic [1:0]  d_alu_src;
    logic [2:0]  d_branch;
    logic        d_mr;
    logic        d_mtr;
    logic        d_mw;
    logic        d_writes;   // instruction class writes rd (before the x0 check)
`ifdef DECODE_ILLEGAL_EN
    logic        d_illegal;
`endif

    always_comb begin
        d_rs1     = in[19:15];
        d_sx      = 32'h0;
        d_zx      = 32'h0;
        d_alu_op  = 3'b111;
        d_alu_src = 2'b00;
        d_branch  = 3'b000;
        d_mr      = 1'b0;
        d_mtr     = 1'b0;
        d_mw      = 1'b0;
        d_writes  = 1'b0;
`ifdef DECODE_ILLEGAL_EN
        d_illegal = 1'b0;
`endif
        case (opcode)
            OP_R: begin
                d_alu_op = 3'b010;
                d_writes = 1'b1;
`ifdef DECODE_ILLEGAL_EN
                if (in[31:25] != 7'b0000000 && in[31:25] != 7'b0100000) begin
                    d_alu_op  = 3'b111;
                    d_writes  = 1'b0;
                    d_illegal = 1'b1;
                end
`endif
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                d_sx      = {{20{in[31]}}, in[31:20]};
                d_zx      = {20'h0, in[31:20]};
                d_alu_src = 2'b01;
                d_writes  = 1'b1;
                if (opcode == OP_IMM) begin
                    d_alu_op = 3'b011;
                end else if (opcode == OP_LOAD) begin
                    d_alu_op = 3'b000;
                    d_mr     = 1'b1;
                    d_mtr    = 1'b1;
                end else begin
                    d_alu_op = 3'b110;
                    d_branch = 3'b111;
                end
            end
            OP_STORE: begin
                d_sx      = {{20{in[31]}}, d_imm_s};
                d_zx      = {20'h0, d_imm_s};
                d_alu_op  = 3'b000;
                d_alu_src = 2'b01;
                d_mw      = 1'b1;
            end
            OP_BRANCH: begin
                d_sx     = {{19{in[31]}}, d_imm_b, 1'b0};
                d_zx     = {19'h0, d_imm_b, 1'b0};
                d_alu_op = 3'b001;
                case (funct3)
                    3'b000:  d_branch = 3'b001;
                    3'b001:  d_branch = 3'b010;
                    3'b100:  d_branch = 3'b011;
                    3'b101:  d_branch = 3'b100;
                    3'b110:  d_branch = 3'b101;
                    3'b111:  d_branch = 3'b110;
                    default: begin
                        // funct3 010/011 are unassigned: illegal control pattern
                        d_alu_op = 3'b111;
`ifdef DECODE_ILLEGAL_EN
                        d_illegal = 1'b1;
`endif
                    end
                endcase
            end
            OP_JAL: begin
                d_rs1     = 5'd0;
                d_sx      = {{11{in[31]}}, in[31], in[19:12], in[20], in[30:21], 1'b0};
                d_zx      = {11'h0, in[31], in[19:12], in[20], in[30:21], 1'b0};
                d_alu_op  = 3'b110;
                d_alu_src = 2'b11;
                d_branch  = 3'b111;
                d_writes  = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                d_rs1     = 5'd0;
                d_sx      = {in[31:12], 12'h0};
                d_zx      = {in[31:12], 12'h0};
                d_alu_op  = (opcode == OP_LUI) ? 3'b100 : 3'b101;
                d_alu_src = (opcode == OP_LUI) ? 2'b01 : 2'b11;
                d_writes  = 1'b1;
            end
            default: begin
`ifdef DECODE_ILLEGAL_EN
                d_illegal = 1'b1;
`endif
            end
        endcase
    end

    // Reset and flush both load the all-zero bubble; flush wins over `in`.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || pc_sel) begin
            rs1          <= 5'd0;
            rs2          <= 5'd0;
            rd           <= 5'd0;
            imm_i        <= 12'h0;
            imm_u        <= 20'h0;
            imm_s        <= 12'h0;
            imm_b        <= 12'h0;
            imm_j        <= 12'h0;
            sign_ext_imm <= 32'h0;
            zero_ext_imm <= 32'h0;
            alu_op       <= 3'b000;
            alu_src      <= 2'b00;
            branch_sel   <= 3'b000;
            mr_sel       <= 1'b0;
            mtr_sel      <= 1'b0;
            mw_sel       <= 1'b0;
            rw_sel       <= 1'b0;
`ifdef DECODE_ILLEGAL_EN
            illegal      <= 1'b0;
`endif
        end else begin
            rs1          <= d_rs1;
            rs2          <= in[24:20];
            rd           <= in[11:7];
            imm_i        <= in[31:20];
            imm_u        <= in[31:12];
            imm_s        <= d_imm_s;
            imm_b        <= d_imm_b;
            imm_j        <= d_imm_j;
            sign_ext_imm <= d_sx;
            zero_ext_imm <= d_zx;
            alu_op       <= d_alu_op;
            alu_src      <= d_alu_src;
            branch_sel   <= d_branch;
            mr_sel       <= d_mr;
            mtr_sel      <= d_mtr;
            mw_sel       <= d_mw;
            rw_sel       <= d_writes && (in[11:7] != 5'd0);
`ifdef DECODE_ILLEGAL_EN
            illegal      <= d_illegal;
`endif
        end
    end

endmodule

// File: tb/tb_rv32i_decode.sv
// tb_rv32i_decode -- bench for rv32i_decode.
// Directed cases use constant expectations; random cases are checked
// against a reference model that computes offsets arithmetically.

module tb_rv32i_decode;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [11:0] imm_i;
        logic [19:0] imm_u;
        logic [11:0] imm_s;
        logic [11:0] imm_b;
        logic [11:0] imm_j;
        logic [31:0] sx;
        logic [31:0] zx;
        logic [2:0]  alu_op;
        logic [1:0]  alu_src;
        logic [2:0]  br;
        logic        mr;
        logic        mtr;
        logic        mw;
        logic        rw;
        logic        ill;
    } dec_t;

    logic        clk;
    logic        rst;
    logic [31:0] in;
    logic        pc_sel;
    logic [4:0]  rs1, rs2, rd;
    logic [11:0] imm_i, imm_s, imm_b, imm_j;
    logic [19:0] imm_u;
    logic [31:0] sign_ext_imm, zero_ext_imm;
    logic [2:0]  alu_op, branch_sel;
    logic [1:0]  alu_src;
    logic        mr_sel, mtr_sel, mw_sel, rw_sel;
    logic        illegal;

    int checks = 0;
    int passes = 0;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    rv32i_decode dut (
        .clk(clk), .rst(rst), .in(in), .pc_sel(pc_sel),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .imm_i(imm_i), .imm_u(imm_u), .imm_s(imm_s), .imm_b(imm_b), .imm_j(imm_j),
        .sign_ext_imm(sign_ext_imm), .zero_ext_imm(zero_ext_imm),
        .alu_op(alu_op), .alu_src(alu_src), .branch_sel(branch_sel),
        .mr_sel(mr_sel), .mtr_sel(mtr_sel), .mw_sel(mw_sel), .rw_sel(rw_sel)
`ifdef DECODE_ILLEGAL_EN
        , .illegal(illegal)
`endif
    );

`ifndef DECODE_ILLEGAL_EN
    assign illegal = 1'b0;
`endif

    dec_t got;
    assign got = {rs1, rs2, rd, imm_i, imm_u, imm_s, imm_b, imm_j,
                  sign_ext_imm, zero_ext_imm, alu_op, alu_src, branch_sel,
                  mr_sel, mtr_sel, mw_sel, rw_sel, illegal};

    // ---------------- reference model ----------------
    function automatic dec_t model(input logic [31:0] ins, input logic flush);
        dec_t e;
        int   v;
        int   u;
        logic writes;
        logic [2:0] btab [8];
        e = '0;
        writes = 1'b0;
        btab = '{3'd1, 3'd2, 3'd0, 3'd0, 3'd3, 3'd4, 3'd5, 3'd6};
        if (flush) return e;
        e.rs1   = ins[19:15];
        e.rs2   = ins[24:20];
        e.rd    = ins[11:7];
        e.imm_i = ins[31:20];
        e.imm_u = ins[31:12];
        e.imm_s = {ins[31:25], ins[11:7]};
        e.imm_b = {ins[31], ins[7], ins[30:25], ins[11:8]};
        e.imm_j = {ins[20], ins[30:21], 1'b0};
        e.alu_op = 3'd7;
        u = 0;
        v = 0;
        case (ins[6:0])
            7'b0110011: begin
                e.alu_op = 3'd2; writes = 1'b1;
`ifdef DECODE_ILLEGAL_EN
                if (ins[31:25] != 7'h00 && ins[31:25] != 7'h20) begin
                    e.alu_op = 3'd7; writes = 1'b0; e.ill = 1'b1;
                end
`endif
            end
            7'b0010011, 7'b0000011, 7'b1100111: begin
                u = int'(ins[31:20]);
                v = ins[31] ? u - 4096 : u;
                e.alu_src = 2'b01; writes = 1'b1;
                if (ins[6:0] == 7'b0010011) e.alu_op = 3'd3;
                else if (ins[6:0] == 7'b0000011) begin
                    e.alu_op = 3'd0; e.mr = 1'b1; e.mtr = 1'b1;
                end else begin
                    e.alu_op = 3'd6; e.br = 3'd7;
                end
            end
            7'b0100011: begin
                u = int'(ins[31:25]) * 32 + int'(ins[11:7]);
                v = ins[31] ? u - 4096 : u;
                e.alu_op = 3'd0; e.alu_src = 2'b01; e.mw = 1'b1;
            end
            7'b1100011: begin
                u = int'(ins[31]) * 4096 + int'(ins[7]) * 2048
                  + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
                v = ins[31] ? u - 8192 : u;
                if (ins[14:12] == 3'd2 || ins[14:12] == 3'd3) begin
                    e.alu_op = 3'd7;
`ifdef DECODE_ILLEGAL_EN
                    e.ill = 1'b1;
`endif
                end else begin
                    e.alu_op = 3'd1;
                    e.br = btab[ins[14:12]];
                end
            end
            7'b1101111: begin
                u = int'(ins[31]) * (1 << 20) + int'(ins[19:12]) * (1 << 12)
                  + int'(ins[20]) * (1 << 11) + int'(ins[30:21]) * 2;
                v = ins[31] ? u - (1 << 21) : u;
                e.rs1 = 5'd0; e.alu_op = 3'd6; e.alu_src = 2'b11;
                e.br = 3'd7; writes = 1'b1;
            end
            7'b0110111, 7'b0010111: begin
                u = int'(ins[31:12]) * 4096;
                v = u;
                e.rs1 = 5'd0; writes = 1'b1;
                e.alu_op  = (ins[6:0] == 7'b0110111) ? 3'd4 : 3'd5;
                e.alu_src = (ins[6:0] == 7'b0110111) ? 2'b01 : 2'b11;
            end
            default: begin
`ifdef DECODE_ILLEGAL_EN
                e.ill = 1'b1;
`endif
            end
        endcase
        e.sx = 32'(v);
        e.zx = 32'(u);
        e.rw = writes && (ins[11:7] != 5'd0);
        return e;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic [31:0] ins, input logic flush);
        @(negedge clk);
        in = ins;
        pc_sel = flush;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        #1;
        checks++;
        if (got !== '0) $display("FAIL reset_initial got=%h exp=0", got);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        drive(32'h002081B3, 1'b0);
        checks++;
        if (rd !== 5'd3) $display("FAIL reset_preload rd got=%0d exp=3", rd);
        else passes++;
        // assert reset between edges: outputs must clear without a clock edge
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (got !== '0) $display("FAIL reset_async got=%h exp=0", got);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(32'h002081B3, 1'b1);
            checks++;
            if (got !== '0) $display("FAIL reset_flush_hold%0d got=%h exp=0", i, got);
            else passes++;
        end
    endtask

    task automatic test_directed;
        drive(32'h002081B3, 1'b0);   // add x3,x1,x2
        checks++;
        if ({rs1, rs2, rd, alu_op, alu_src, rw_sel, mr_sel, mw_sel, mtr_sel, branch_sel, sign_ext_imm}
            !== {5'd1, 5'd2, 5'd3, 3'b010, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0})
            $display("FAIL add got=%h exp=%h", got, model(32'h002081B3, 1'b0));
        else passes++;

        drive(32'h06320813, 1'b0);   // addi x16,x4,99
        checks++;
        if ({rs1, rd, imm_i, sign_ext_imm, zero_ext_imm, alu_op, alu_src, rw_sel}
            !== {5'd4, 5'd16, 12'h063, 32'h63, 32'h63, 3'b011, 2'b01, 1'b1})
            $display("FAIL addi got=%h exp=%h", got, model(32'h06320813, 1'b0));
        else passes++;

        drive(32'hFFC12083, 1'b0);   // lw x1,-4(x2)
        checks++;
        if ({sign_ext_imm, zero_ext_imm, mr_sel, mtr_sel, rw_sel, mw_sel, alu_op, alu_src}
            !== {32'hFFFFFFFC, 32'h00000FFC, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 2'b01})
            $display("FAIL lw got=%h exp=%h", got, model(32'hFFC12083, 1'b0));
        else passes++;

        drive(32'hFE208EE3, 1'b0);   // beq x1,x2,-4
        checks++;
        if ({branch_sel, alu_op, alu_src, rw_sel, sign_ext_imm}
            !== {3'b001, 3'b001, 2'b00, 1'b0, 32'hFFFFFFFC})
            $display("FAIL beq got=%h exp=%h", got, model(32'hFE208EE3, 1'b0));
        else passes++;

        drive(32'hFE208EE3, 1'b1);   // same word, flushed
        checks++;
        if (got !== '0) $display("FAIL beq_flush got=%h exp=0", got);
        else passes++;

        drive(32'h00000013, 1'b0);   // addi x0,x0,0
        checks++;
        if ({rw_sel, alu_op, alu_src} !== {1'b0, 3'b011, 2'b01})
            $display("FAIL nop_rd0 got=%h exp=%h", got, model(32'h00000013, 1'b0));
        else passes++;

        drive(32'hFFFFFFFF, 1'b0);   // illegal opcode
        checks++;
        if ({alu_op, alu_src, branch_sel, mr_sel, mtr_sel, mw_sel, rw_sel, sign_ext_imm, rs1}
            !== {3'b111, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd31})
            $display("FAIL illegal_op got=%h exp=%h", got, model(32'hFFFFFFFF, 1'b0));
        else passes++;
`ifdef DECODE_ILLEGAL_EN
        checks++;
        if (illegal !== 1'b1) $display("FAIL illegal_flag got=%b exp=1", illegal);
        else passes++;
`endif
    endtask

    task automatic test_random;
        logic [6:0]  ops [9];
        logic [31:0] ins;
        logic        fl;
        dec_t        exp;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        for (int n = 0; n < 400; n++) begin
            ins = $urandom();
            if ($urandom_range(0, 7) != 0)
                ins[6:0] = ops[$urandom_range(0, 8)];
            if (ins[6:0] == 7'b0110011 && $urandom_range(0, 3) != 0)
                ins[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
            if ($urandom_range(0, 9) == 0)
                ins[11:7] = 5'd0;
            fl = ($urandom_range(0, 9) == 0);
            exp = model(ins, fl);
            drive(ins, fl);
            checks++;
            if (got !== exp)
                $display("FAIL random%0d in=%h flush=%b got=%h exp=%h", n, ins, fl, got, exp);
            else passes++;
        end
    endtask

    initial begin
        rst = 1'b1;
        in = 32'h0;
        pc_sel = 1'b0;
        test_reset();
        test_directed();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
